sw_ctrl_fsm: RTL and testbench

//   Stopwatch control front-end, directly upstream of the seconds counter.

---
 rtl/sw_pkg.sv | 11 +
 rtl/sw_btn_debounce.sv | 40 ++++
 rtl/sw_ctrl_fsm.sv | 65 ++++++
 tb/tb_sw_ctrl_fsm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding and default timing constants for the stopwatch control front-end
package sw_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLEAR = 2'd3
    } sw_state_t;
    localparam int DB_CYCLES_DEF  = 16;
    localparam int CLR_CYCLES_DEF = 2;
endpackage

// File: rtl/sw_btn_debounce.sv
// sw_btn_debounce: 2-FF sync, debounce and rising-edge press pulse for one raw button
// Ports: clk, rst (async, active-high), i_raw (raw button),
//        o_level (debounced level), o_press (1-cycle pulse on accepted press)
module sw_btn_debounce
    import sw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int DBW       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    logic           r_sync1, r_sync2, r_stable, r_stable_d;
    logic [DBW-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable)
                r_cnt <= '0;
            else if (r_cnt == DBW'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else
                r_cnt <= r_cnt + DBW'(1);
        end
    end
    assign o_level = r_stable;
    assign o_press = r_stable & ~r_stable_d;
endmodule

// File: rtl/sw_ctrl_fsm.sv
// sw_ctrl_fsm: stopwatch control FSM driving the seconds counter from two debounced buttons
// Ports: clk, rst (async, active-high), i_btn_ss / i_btn_clr (raw buttons),
//        i_ovf (counter overflow pulse), o_sw_en, o_start_stop, o_reset,
//        o_ovf_seen (sticky overflow), o_state (current state)
module sw_ctrl_fsm
    import sw_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int DBW        = 5,
    parameter int CLR_CYCLES = CLR_CYCLES_DEF,
    parameter int CLW        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_btn_ss,
    input  logic       i_btn_clr,
    input  logic       i_ovf,
    output logic       o_sw_en,
    output logic       o_start_stop,
    output logic       o_reset,
    output logic       o_ovf_seen,
    output logic [1:0] o_state
);
    sw_state_t      r_state, w_next;
    logic [CLW-1:0] r_clr_cnt;
    logic           r_ovf_seen;
    logic           w_ss_press, w_clr_press, w_clr_done;
    logic           w_unused_ss_level, w_unused_clr_level;
    sw_btn_debounce #(.DB_CYCLES(DB_CYCLES), .DBW(DBW)) u_ss (
        .clk(clk), .rst(rst), .i_raw(i_btn_ss),
        .o_level(w_unused_ss_level), .o_press(w_ss_press)
    );
    sw_btn_debounce #(.DB_CYCLES(DB_CYCLES), .DBW(DBW)) u_clr (
        .clk(clk), .rst(rst), .i_raw(i_btn_clr),
        .o_level(w_unused_clr_level), .o_press(w_clr_press)
    );
    assign w_clr_done = r_clr_cnt == CLW'(CLR_CYCLES - 1);
    // clear has priority over start/stop; presses seen while in CLEAR are dropped
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_PAUSE: w_next = w_clr_press ? ST_CLEAR : w_ss_press ? ST_RUN : r_state;
            ST_RUN:            w_next = w_clr_press ? ST_CLEAR : w_ss_press ? ST_PAUSE : ST_RUN;
            ST_CLEAR:          w_next = w_clr_done ? ST_IDLE : ST_CLEAR;
            default:           w_next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_clr_cnt  <= '0;
            r_ovf_seen <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_clr_cnt  <= (r_state == ST_CLEAR && !w_clr_done) ? r_clr_cnt + CLW'(1) : '0;
            // entering CLEAR wipes the flag; overflows during CLEAR are ignored
            r_ovf_seen <= (w_next == ST_CLEAR) ? 1'b0 : r_ovf_seen | (i_ovf & (r_state != ST_CLEAR));
        end
    end
    assign o_sw_en      = r_state != ST_CLEAR;
    assign o_start_stop = r_state == ST_RUN;
    assign o_reset      = r_state == ST_CLEAR;
    assign o_ovf_seen   = r_ovf_seen;
    assign o_state      = r_state;
endmodule

// File: tb/tb_sw_ctrl_fsm.sv
// tb_sw_ctrl_fsm: directed bench with a behavioural stopwatch model checked every cycle
module tb_sw_ctrl_fsm;
    localparam int DB  = 4;
    localparam int CLR = 2;
    logic       clk = 1'b0, rst = 1'b1, btn_ss = 1'b0, btn_clr = 1'b0, ovf = 1'b0;
    logic       sw_en, start_stop, reset_o, ovf_seen;
    logic [1:0] state;
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    sw_ctrl_fsm #(.DB_CYCLES(DB), .DBW(3), .CLR_CYCLES(CLR), .CLW(2)) dut (
        .clk(clk), .rst(rst), .i_btn_ss(btn_ss), .i_btn_clr(btn_clr), .i_ovf(ovf),
        .o_sw_en(sw_en), .o_start_stop(start_stop), .o_reset(reset_o),
        .o_ovf_seen(ovf_seen), .o_state(state)
    );
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: mode 0 idle, 1 run, 2 pause, 3 clear. A button level is accepted once the
    // last DB synchroniser outputs all disagree with the accepted level; an accepted
    // press acts on the mode one edge later.
    int         m_mode = 0, m_left = 0, m_nm;
    bit         m_ovf = 1'b0;
    bit [DB:0]  m_sh [2];
    bit         m_stb [2];
    bit         m_pend [2];
    bit [1:0]   m_raw;
    bit         m_flip;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0;
            m_left = 0;
            m_ovf  = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_sh[b]   = '0;
                m_stb[b]  = 1'b0;
                m_pend[b] = 1'b0;
            end
        end else begin
            m_nm = m_mode;
            if (m_mode == 3) begin
                if (m_left == 1) m_nm = 0;
                else m_left = m_left - 1;
            end else if (m_pend[1]) begin
                m_nm   = 3;
                m_left = CLR;
            end else if (m_pend[0])
                m_nm = (m_mode == 1) ? 2 : 1;
            if (m_nm == 3) m_ovf = 1'b0;
            else if (m_mode != 3) m_ovf = m_ovf | ovf;
            m_mode = m_nm;
            m_raw = {btn_clr, btn_ss};
            for (int b = 0; b < 2; b++) begin
                m_flip    = m_stb[b] ? (m_sh[b][DB:1] == '0) : (&m_sh[b][DB:1]);
                m_pend[b] = m_flip && !m_stb[b];
                if (m_flip) m_stb[b] = !m_stb[b];
                m_sh[b] = {m_sh[b][DB-1:0], m_raw[b]};
            end
        end
    end
    always @(negedge clk)
        check("cycle_outputs", {2'b0, sw_en, start_stop, reset_o, ovf_seen, state},
              {2'b0, m_mode != 3, m_mode == 1, m_mode == 3, m_ovf, 2'(m_mode)});
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic press(input bit ss, input bit cl, input int hold);
        btn_ss  = ss;
        btn_clr = cl;
        step(hold);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        step(10);
    endtask
    initial begin
        step(3);
        rst = 1'b0;
        step(1);
        check("reset_outputs", {sw_en, start_stop, reset_o, ovf_seen, state}, 8'b10_0000);
        btn_ss = 1'b1;
        step(6);
        check("ss_edge6_state", state, 8'd0);
        step(1);
        check("ss_edge7_state", state, 8'd1);
        check("ss_edge7_run", start_stop, 8'd1);
        step(5);
        btn_ss = 1'b0;
        step(10);
        press(1'b1, 1'b0, 12);
        check("pause_state", state, 8'd2);
        check("pause_ss", start_stop, 8'd0);
        for (int i = 0; i < 4; i++) begin
            btn_ss = (i % 2 == 0);
            step(1);
        end
        btn_ss = 1'b0;
        step(12);
        check("bounce_state", state, 8'd2);
        check("bounce_ss", start_stop, 8'd0);
        press(1'b1, 1'b0, DB - 1);
        check("short_pulse_state", state, 8'd2);
        press(1'b1, 1'b0, 12);
        check("run_again", state, 8'd1);
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        step(7);
        check("both_clear_state", state, 8'd3);
        check("both_clear_rst_en", {reset_o, sw_en}, 8'b10);
        step(1);
        check("clear_second_cycle", state, 8'd3);
        step(1);
        check("clear_exit_state", state, 8'd0);
        check("clear_exit_rst_en", {reset_o, sw_en}, 8'b01);
        step(3);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        step(12);
        check("no_toggle_after_clear", state, 8'd0);
        press(1'b1, 1'b0, 12);
        ovf = 1'b1;
        step(1);
        ovf = 1'b0;
        check("ovf_set", ovf_seen, 8'd1);
        press(1'b1, 1'b0, 12);
        check("ovf_pause_state", state, 8'd2);
        check("ovf_held_pause", ovf_seen, 8'd1);
        btn_clr = 1'b1;
        step(7);
        check("ovf_clear_entry", {state, ovf_seen}, 8'b110);
        ovf = 1'b1;
        step(1);
        ovf = 1'b0;
        check("ovf_ignored_in_clear", ovf_seen, 8'd0);
        step(5);
        btn_clr = 1'b0;
        step(10);
        check("ovf_after_clear", {state, ovf_seen}, 8'b000);
        press(1'b1, 1'b0, 12);
        check("run_before_rst", state, 8'd1);
        btn_ss = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {sw_en, start_stop, reset_o, ovf_seen, state}, 8'b10_0000);
        btn_ss = 1'b0;
        step(2);
        rst = 1'b0;
        step(15);
        check("no_spurious_press", state, 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
